// File: rtl/bus_timer_pkg.sv
// Shared register map and field positions for the bus_timer peripheral,
// plus the byte-lane merge used by every writable register.
package bus_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_off_e;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_AUTO_BIT  = 1;
    localparam int unsigned CTRL_IE_BIT    = 2;
    localparam int unsigned STATUS_EXP_BIT = 0;

    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Split read/write request-grant bus used to reach the timer registers.
interface bus_timer_if;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer: prescaled tick, one-shot or auto-reload,
// write-1-to-clear expiry flag and level interrupt.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 50
) (
    input  logic       clk,
    input  logic       rst,
    bus_timer_if.slave bus,
    output logic       irq
);

    localparam int unsigned   PW         = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic          ctrl_en, ctrl_auto, ctrl_ie, exp_q;
    logic [31:0]   load_q, count_q, rd_data_q;
    logic [PW-1:0] presc_q;

    logic          ctrl_en_d, ctrl_auto_d, ctrl_ie_d, exp_d;
    logic [31:0]   load_d, count_d, rd_word, ctrl_word, ctrl_wr, status_word;
    logic [PW-1:0] presc_d;
    reg_off_e      wr_off, rd_off;
    logic          wr_any, wr_ctrl, wr_load, wr_count, wr_status;
    logic          tick, expire;
    logic          unused_addr;

    assign unused_addr = ^{bus.rd_addr[31:4], bus.rd_addr[1:0],
                           bus.wr_addr[31:4], bus.wr_addr[1:0]};

    assign bus.rd_gnt  = bus.rd_req;
    assign bus.wr_gnt  = bus.wr_req;
    assign bus.rd_data = rd_data_q;
    assign irq         = exp_q & ctrl_ie;

    assign wr_off    = reg_off_e'(bus.wr_addr[3:2]);
    assign rd_off    = reg_off_e'(bus.rd_addr[3:2]);
    assign wr_any    = bus.wr_req && (bus.wr_be != 4'b0000);
    assign wr_ctrl   = wr_any && (wr_off == REG_CTRL) && bus.wr_be[0];
    assign wr_load   = wr_any && (wr_off == REG_LOAD);
    assign wr_count  = wr_any && (wr_off == REG_COUNT);
    assign wr_status = wr_any && (wr_off == REG_STATUS) && bus.wr_be[0];

    assign tick   = ctrl_en && (presc_q == PRESC_LAST);
    assign expire = tick && (count_q == '0);

    always_comb begin
        ctrl_word                  = '0;
        ctrl_word[CTRL_EN_BIT]     = ctrl_en;
        ctrl_word[CTRL_AUTO_BIT]   = ctrl_auto;
        ctrl_word[CTRL_IE_BIT]     = ctrl_ie;
        status_word                = '0;
        status_word[STATUS_EXP_BIT] = exp_q;
        unique case (rd_off)
            REG_CTRL:   rd_word = ctrl_word;
            REG_LOAD:   rd_word = load_q;
            REG_COUNT:  rd_word = count_q;
            REG_STATUS: rd_word = status_word;
        endcase
    end

    // Priority is expressed by assignment order: later statements win.
    always_comb begin
        ctrl_wr     = be_merge(ctrl_word, bus.wr_data, bus.wr_be);
        ctrl_en_d   = ctrl_en;
        ctrl_auto_d = ctrl_auto;
        ctrl_ie_d   = ctrl_ie;
        if (expire && !ctrl_auto) ctrl_en_d = 1'b0;
        if (wr_ctrl) begin
            ctrl_en_d   = ctrl_wr[CTRL_EN_BIT];
            ctrl_auto_d = ctrl_wr[CTRL_AUTO_BIT];
            ctrl_ie_d   = ctrl_wr[CTRL_IE_BIT];
        end

        load_d = wr_load ? be_merge(load_q, bus.wr_data, bus.wr_be) : load_q;

        count_d = count_q;
        if (tick) begin
            if (count_q != '0)  count_d = count_q - 32'd1;
            else if (ctrl_auto) count_d = load_q;
        end
        if (wr_load)       count_d = load_d;
        else if (wr_count) count_d = be_merge(count_q, bus.wr_data, bus.wr_be);

        exp_d = exp_q;
        if (wr_status && bus.wr_data[STATUS_EXP_BIT]) exp_d = 1'b0;
        if (expire) exp_d = 1'b1;

        if (!ctrl_en || tick) presc_d = '0;
        else                  presc_d = presc_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
            load_q    <= '0;
            count_q   <= '0;
            exp_q     <= 1'b0;
            presc_q   <= '0;
            rd_data_q <= '0;
        end else begin
            ctrl_en   <= ctrl_en_d;
            ctrl_auto <= ctrl_auto_d;
            ctrl_ie   <= ctrl_ie_d;
            load_q    <= load_d;
            count_q   <= count_d;
            exp_q     <= exp_d;
            presc_q   <= presc_d;
            if (bus.rd_req) rd_data_q <= rd_word;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer with PRESCALE=4.
module tb_bus_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_seq [9] = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};

    bus_timer_if bus ();

    bus_timer #(.PRESCALE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.wr_req  = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        bus.wr_be   = be;
        #1;
        check("wr_gnt", 32'(bus.wr_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
        bus.wr_be  = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        #1;
        check("rd_gnt", 32'(bus.rd_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        data = bus.rd_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int unsigned bad;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;

        // Reset state
        #1;
        check("irq_in_reset", 32'(irq), 32'd0);
        check("rd_data_in_reset", bus.rd_data, 32'd0);
        check("rd_gnt_idle", 32'(bus.rd_gnt), 32'd0);
        check("wr_gnt_idle", 32'(bus.wr_gnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int unsigned r = 0; r < 4; r++) begin
            bus_read(32'(r * 4), d);
            check("reg_after_reset", d, 32'd0);
        end

        // Partial byte-lane LOAD write copies into COUNT
        do_reset();
        bus_write(32'h4, 32'h1234_5678, 4'b0101);
        bus_read(32'h4, d);
        check("load_be0101", d, 32'h0034_0078);
        bus_read(32'h8, d);
        check("count_be0101", d, 32'h0034_0078);
        bus_read(32'hFFFF_FFF4, d);
        check("load_alias_addr", d, 32'h0034_0078);
        bus_write(32'h8, 32'hFFFF_FFFF, 4'b0000);
        bus_read(32'h8, d);
        check("count_be0_noop", d, 32'h0034_0078);

        // Same-cycle read and write of LOAD returns the old contents
        bus.rd_req = 1'b1; bus.rd_addr = 32'h4;
        bus_write(32'h4, 32'hAABB_CCDD, 4'hF);
        bus.rd_req = 1'b0;
        check("rd_during_wr_old", bus.rd_data, 32'h0034_0078);
        bus_read(32'h4, d);
        check("load_full_write", d, 32'hAABB_CCDD);
        @(posedge clk);
        #1;
        check("rd_data_holds", bus.rd_data, 32'hAABB_CCDD);

        // One-shot: LOAD=3, CTRL=EN|IE -> expiry 16 cycles after CTRL write
        bus_write(32'h4, 32'd3, 4'hF);
        bus_write(32'h0, 32'h5, 4'hF);
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            if (n == 15) check("oneshot_irq_pre", 32'(irq), 32'd0);
            if (n == 16) check("oneshot_irq_rise", 32'(irq), 32'd1);
        end
        bus_read(32'hC, d);
        check("oneshot_exp", d, 32'd1);
        bus_read(32'h0, d);
        check("oneshot_en_cleared", d, 32'h4);
        bus_read(32'h8, d);
        check("oneshot_count0", d, 32'd0);
        bus_write(32'hC, 32'h1, 4'h1);
        check("w1c_irq_low", 32'(irq), 32'd0);

        // Auto-reload: LOAD=2, CTRL=7; COUNT streamed through a held read
        bus_write(32'h4, 32'd2, 4'hF);
        bus.rd_req = 1'b1; bus.rd_addr = 32'h8;
        bus_write(32'h0, 32'h7, 4'hF);
        for (int n = 1; n <= 38; n++) begin
            @(posedge clk);
            #1;
            if (n == 14 || n == 26 || n == 36 || n == 38) bus.wr_req = 1'b0;
            if (n <= 34 && n % 4 == 2) check("auto_count_seq", bus.rd_data, exp_seq[(n - 2) / 4]);
            case (n)
                11, 23, 35: check("auto_irq_pre", 32'(irq), 32'd0);
                12, 24:     check("auto_irq_rise", 32'(irq), 32'd1);
                14, 26, 38: check("auto_w1c_clear", 32'(irq), 32'd0);
                36:         check("exp_set_beats_w1c", 32'(irq), 32'd1);
                default: ;
            endcase
            if (n == 13 || n == 25 || n == 35 || n == 37) begin
                bus.wr_req = 1'b1; bus.wr_addr = 32'hC; bus.wr_data = 32'h1; bus.wr_be = 4'h1;
            end
        end
        bus.rd_req = 1'b0;
        bus_write(32'h0, 32'h0, 4'hF);

        // Reset mid-count abandons everything
        bus_write(32'h4, 32'd0, 4'hF);
        bus_write(32'h0, 32'h5, 4'hF);
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_irq", 32'(irq), 32'd1);
        bus_write(32'h4, 32'd5, 4'hF);
        bus_write(32'h0, 32'h5, 4'hF);
        bus_read(32'h8, d);
        check("pre_rst_count5", d, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_rd_data", bus.rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int unsigned r = 0; r < 4; r++) begin
            bus_read(32'(r * 4), d);
            check("reg_after_mid_rst", d, 32'd0);
        end
        bad = 0;
        bus.rd_req = 1'b1; bus.rd_addr = 32'hC;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.rd_data !== 32'd0 || irq !== 1'b0) bad++;
        end
        bus.rd_req = 1'b0;
        check("no_exp_after_rst", 32'(bad), 32'd0);
        bus_read(32'h8, d);
        check("count_idle_after_rst", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 50, meaning clk cycles per timer tick (1 us at 50 MHz); legal range 1..65535.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have rd_req  input  1  bus read request.
REQ-005 SHALL have rd_gnt  output  1  read grant.
REQ-006 SHALL have rd_addr  input  32  read byte address; only bits [3:2] decoded.
REQ-007 SHALL have rd_data  output  32  read data.
REQ-008 SHALL have wr_req  input  1  bus write request.
REQ-009 SHALL have wr_gnt  output  1  write grant.
REQ-010 SHALL have wr_addr  input  32  write byte address; only bits [3:2] decoded.
REQ-011 SHALL have wr_data  input  32  write data.
REQ-012 SHALL have wr_be  input  4  byte enables; bit n qualifies wr_data[8n+7:8n].
REQ-013 SHALL have irq  output  1  level interrupt.

Function
REQ-014 SHALL map registers at word offsets: 0 CTRL (bit0 EN, bit1 AUTO, bit2 IE, rest read 0), 1 LOAD (32 b), 2 COUNT (32 b), 3 STATUS (bit0 EXP, rest read 0).
REQ-015 SHALL assert rd_gnt = rd_req and wr_gnt = wr_req combinationally; the block never stalls.
REQ-016 SHALL register rd_data on the edge of a granted read, valid the following cycle; rd_data holds its value until the next granted read.
REQ-017 SHALL apply a granted write on the same edge, per byte lane per wr_be; wr_be = 0 has no effect.
REQ-018 SHALL make a LOAD write also copy the resulting LOAD value into COUNT on the same edge; a COUNT write sets COUNT directly.
REQ-019 SHALL treat STATUS.EXP as write-1-to-clear; writing 0 has no effect.
REQ-020 SHALL run a prescaler 0..PRESCALE-1 while EN=1, producing a one-cycle tick when it equals PRESCALE-1; the prescaler wraps to 0 on tick.
REQ-021 SHALL clear the prescaler to 0 whenever EN=0, so the first tick after enabling occurs exactly PRESCALE cycles after the CTRL write edge.
REQ-022 SHALL, on tick with COUNT != 0, decrement COUNT by 1.
REQ-023 SHALL, on tick with COUNT == 0: set EXP; if AUTO=1 reload COUNT from LOAD and keep EN; if AUTO=0 keep COUNT=0 and clear EN (one-shot).
REQ-024 SHALL resolve same-cycle events as follows: bus write to COUNT or LOAD overrides tick update of COUNT; bus write to CTRL overrides hardware EN clear; hardware EXP set overrides W1C clear.
REQ-025 SHALL drive irq = EXP AND IE, derived only from registered state (no combinational path from bus inputs).
REQ-026 SHALL return current register contents (pre-update) for a read and write to the same register in the same cycle.

Reset
REQ-027 SHALL, on rst, asynchronously clear CTRL, LOAD, COUNT, EXP, the prescaler and rd_data to 0; irq is 0 during and after reset.
REQ-028 SHALL, if rst asserts mid-count, abandon the count with no tick or EXP generated; counting resumes only after software sets EN.

Structure
REQ-029 SHALL place register word-offset constants and CTRL/STATUS bit-position constants in the shared SoC package.
REQ-030 SHALL be a single module with no sub-module; the prescaler is an internal counter of width $clog2(PRESCALE+1).

Verification
REQ-031 SHALL cover: PRESCALE=4, write LOAD=3, CTRL=0x5 -> EXP and irq rise exactly 16 cycles after the CTRL write edge, EN reads 0.
REQ-032 SHALL cover: LOAD=2, CTRL=0x7 -> EXP set every 12 cycles (PRESCALE=4), COUNT sequence 2,1,0,2,1,0.
REQ-033 SHALL cover: write STATUS=1 on the same edge as the hardware EXP set -> EXP remains 1; a later STATUS=1 write clears EXP and irq.
REQ-034 SHALL cover: write LOAD=0x12345678 with wr_be=0b0101 after reset -> LOAD and COUNT read 0x00340078, data valid one cycle after rd_gnt.
REQ-035 SHALL cover: assert rst while COUNT=5 and EN=1 -> all registers read 0 and irq=0; no EXP for 100 cycles after release.
